xrmem_arbn: RTL and testbench

XRMEM_ARBN -- requirements
Module: xrmem_arbn

---
 rtl/xrmem_arbn.sv | 184 ++++++++++++++++++
 tb/tb_xrmem_arbn.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/xrmem_arbn.sv
// Arbitrates the host and NUM_WR write-only masters onto the XR registers and the color/tile/copper memories.
// Writes are driven in the grant cycle. Acks are registered one cycle later. Host reads yield to video reads.
module xrmem_arbn #(
   parameter int NUM_WR     = 2,
   parameter int RR_EN      = 1,
   parameter int STARVE_MAX = 7
) (
   input  logic                 clk,
   input  logic                 reset_ni,
   input  logic                 host_sel_i,
   input  logic                 host_wr_i,
   input  logic [15:0]          host_addr_i,
   input  logic [15:0]          host_data_i,
   output logic                 host_ack_o,
   output logic [15:0]          host_data_o,
   input  logic [NUM_WR-1:0]    wm_sel_i,
   output logic [NUM_WR-1:0]    wm_ack_o,
   input  logic [16*NUM_WR-1:0] wm_addr_i,
   input  logic [16*NUM_WR-1:0] wm_data_i,
   output logic                 xreg_wr_o,
   output logic [15:0]          xreg_addr_o,
   output logic [15:0]          xreg_data_o,
   input  logic [15:0]          xreg_data_i,
   output logic [2:0]           mem_wr_en_o,
   output logic [15:0]          mem_wr_addr_o,
   output logic [15:0]          mem_wr_data_o,
   input  logic [2:0]           vid_sel_i,
   input  logic [47:0]          vid_addr_i,
   output logic [2:0]           mem_rd_en_o,
   output logic [47:0]          mem_rd_addr_o,
   input  logic [47:0]          mem_rd_data_i
);

   localparam logic [2:0] RG_REGS   = 3'd0;
   localparam logic [2:0] RG_COLOR  = 3'd1;
   localparam logic [2:0] RG_TILE   = 3'd2;
   localparam logic [2:0] RG_COPPER = 3'd3;
   localparam logic [2:0] RG_NONE   = 3'd4;

   function automatic logic [2:0] decode(input logic [15:0] a);
      logic [2:0] r;
      r = RG_NONE;
      if (!a[15])                r = RG_REGS;
      else if (a[14:13] == 2'b00) r = RG_COLOR;
      else if (a[14:13] == 2'b01) r = RG_TILE;
      else if (a[14:13] == 2'b10) r = RG_COPPER;
      return r;
   endfunction

   logic [1:0]        rr_ptr;
   logic [3:0]        starve_cnt;
   logic              host_ack_q;
   logic              rd_ack_q;
   logic [2:0]        rd_rgn_q;
   logic [15:0]       rd_hold_q;
   logic [NUM_WR-1:0] wm_ack_q;

   logic              host_wpend, host_rpend, host_force;
   logic              host_wgnt, host_rgnt, m_any, m_gnt, m_win_pend, wr_vld;
   logic              hi_found;
   logic [1:0]        hi_idx, lo_idx, m_win;
   logic [15:0]       m_addr, m_data, wr_addr, wr_data, rd_live;
   logic [2:0]        wr_rgn, host_rgn;
   logic [NUM_WR-1:0] m_gnt_vec;

   // The winner is chosen among masters holding sel, so a master keeps its slot through its
   // own ack cycle: a held request under fixed priority shuts out lower masters and the host.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int i = NUM_WR - 1; i >= 0; i--) begin
         if (wm_sel_i[i]) begin
            lo_idx = 2'(i);
            if (2'(i) >= rr_ptr) begin
               hi_idx   = 2'(i);
               hi_found = 1'b1;
            end
         end
      end
      m_win = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      m_addr     = '0;
      m_data     = '0;
      m_win_pend = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (m_win == 2'(i)) begin
            m_addr     = wm_addr_i[16*i +: 16];
            m_data     = wm_data_i[16*i +: 16];
            m_win_pend = wm_sel_i[i] & ~wm_ack_q[i];
         end
      end
   end

   assign host_rgn   = decode(host_addr_i);
   assign host_wpend = host_sel_i & host_wr_i & ~host_ack_q;
   assign host_rpend = host_sel_i & ~host_wr_i & ~host_ack_q;
   assign host_force = host_wpend && (starve_cnt == 4'(STARVE_MAX));
   assign m_any      = |wm_sel_i;
   assign host_wgnt  = reset_ni & host_wpend & (host_force | ~m_any);
   assign m_gnt      = reset_ni & m_any & ~host_wgnt & m_win_pend;
   assign wr_vld     = host_wgnt | m_gnt;
   assign wr_addr    = host_wgnt ? host_addr_i : m_addr;
   assign wr_data    = host_wgnt ? host_data_i : m_data;
   assign wr_rgn     = decode(wr_addr);

   always_comb begin
      m_gnt_vec = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         m_gnt_vec[i] = m_gnt && (m_win == 2'(i));
      end
   end

   assign xreg_wr_o     = wr_vld && (wr_rgn == RG_REGS);
   assign xreg_addr_o   = xreg_wr_o ? wr_addr : host_addr_i;
   assign xreg_data_o   = wr_data;
   assign mem_wr_en_o   = {wr_vld && (wr_rgn == RG_COPPER),
                           wr_vld && (wr_rgn == RG_TILE),
                           wr_vld && (wr_rgn == RG_COLOR)};
   assign mem_wr_addr_o = wr_addr;
   assign mem_wr_data_o = wr_data;

   always_comb begin
      host_rgnt = 1'b0;
      if (reset_ni && host_rpend) begin
         case (host_rgn)
            RG_REGS:   host_rgnt = !xreg_wr_o;
            RG_COLOR:  host_rgnt = !vid_sel_i[0];
            RG_TILE:   host_rgnt = !vid_sel_i[1];
            RG_COPPER: host_rgnt = !vid_sel_i[2];
            default:   host_rgnt = 1'b1;
         endcase
      end
   end

   // Video owns a region's read port whenever it asks; the host only gets the idle ones.
   always_comb begin
      mem_rd_en_o   = '0;
      mem_rd_addr_o = '0;
      for (int r = 0; r < 3; r++) begin
         mem_rd_en_o[r] = vid_sel_i[r] | (host_rgnt && (host_rgn == 3'(r + 1)));
         mem_rd_addr_o[16*r +: 16] = vid_sel_i[r] ? vid_addr_i[16*r +: 16] : host_addr_i;
      end
   end

   always_comb begin
      case (rd_rgn_q)
         RG_REGS:   rd_live = xreg_data_i;
         RG_COLOR:  rd_live = mem_rd_data_i[15:0];
         RG_TILE:   rd_live = mem_rd_data_i[31:16];
         RG_COPPER: rd_live = mem_rd_data_i[47:32];
         default:   rd_live = 16'h0000;
      endcase
   end

   assign host_data_o = rd_ack_q ? rd_live : rd_hold_q;
   assign host_ack_o  = host_ack_q;
   assign wm_ack_o    = wm_ack_q;

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         host_ack_q <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_rgn_q   <= RG_REGS;
         rd_hold_q  <= 16'h0000;
         wm_ack_q   <= '0;
         starve_cnt <= '0;
         rr_ptr     <= '0;
      end else begin
         host_ack_q <= host_wgnt | host_rgnt;
         rd_ack_q   <= host_rgnt;
         wm_ack_q   <= m_gnt_vec;
         if (host_rgnt) rd_rgn_q <= host_rgn;
         if (rd_ack_q)  rd_hold_q <= rd_live;
         if (host_wpend && !host_wgnt) starve_cnt <= starve_cnt + 4'd1;
         else                          starve_cnt <= '0;
         if ((RR_EN != 0) && m_gnt)
            rr_ptr <= (m_win == 2'(NUM_WR - 1)) ? 2'd0 : m_win + 2'd1;
      end
   end

endmodule

// File: tb/tb_xrmem_arbn.sv
// Directed bench: round-robin/starvation instance plus a fixed-priority instance sharing the same stimulus.
module tb_xrmem_arbn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_ni, host_sel, host_wr;
   logic [15:0] host_addr, host_data, xreg_rdat;
   logic [1:0]  wm_sel;
   logic [31:0] wm_addr, wm_data;
   logic [2:0]  vid_sel;
   logic [47:0] vid_addr, mem_rdat;

   logic        host_ack, xreg_wr;
   logic [15:0] host_rdat, xreg_addr, xreg_wdat, mem_wr_addr, mem_wr_data;
   logic [1:0]  wm_ack;
   logic [2:0]  mem_wr_en, mem_rd_en;
   logic [47:0] mem_rd_addr;

   logic        fp_host_ack, fp_xreg_wr;
   logic [15:0] fp_host_rdat, fp_xreg_addr, fp_xreg_wdat, fp_mem_wr_addr, fp_mem_wr_data;
   logic [1:0]  fp_wm_ack;
   logic [2:0]  fp_mem_wr_en, fp_mem_rd_en;
   logic [47:0] fp_mem_rd_addr;

   int total = 0;
   int bad   = 0;

   xrmem_arbn #(.NUM_WR(2), .RR_EN(1), .STARVE_MAX(3)) u_rr (
      .clk(clk), .reset_ni(reset_ni),
      .host_sel_i(host_sel), .host_wr_i(host_wr), .host_addr_i(host_addr), .host_data_i(host_data),
      .host_ack_o(host_ack), .host_data_o(host_rdat),
      .wm_sel_i(wm_sel), .wm_ack_o(wm_ack), .wm_addr_i(wm_addr), .wm_data_i(wm_data),
      .xreg_wr_o(xreg_wr), .xreg_addr_o(xreg_addr), .xreg_data_o(xreg_wdat), .xreg_data_i(xreg_rdat),
      .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
      .vid_sel_i(vid_sel), .vid_addr_i(vid_addr),
      .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rdat)
   );

   xrmem_arbn #(.NUM_WR(2), .RR_EN(0), .STARVE_MAX(3)) u_fp (
      .clk(clk), .reset_ni(reset_ni),
      .host_sel_i(host_sel), .host_wr_i(host_wr), .host_addr_i(host_addr), .host_data_i(host_data),
      .host_ack_o(fp_host_ack), .host_data_o(fp_host_rdat),
      .wm_sel_i(wm_sel), .wm_ack_o(fp_wm_ack), .wm_addr_i(wm_addr), .wm_data_i(wm_data),
      .xreg_wr_o(fp_xreg_wr), .xreg_addr_o(fp_xreg_addr), .xreg_data_o(fp_xreg_wdat), .xreg_data_i(xreg_rdat),
      .mem_wr_en_o(fp_mem_wr_en), .mem_wr_addr_o(fp_mem_wr_addr), .mem_wr_data_o(fp_mem_wr_data),
      .vid_sel_i(vid_sel), .vid_addr_i(vid_addr),
      .mem_rd_en_o(fp_mem_rd_en), .mem_rd_addr_o(fp_mem_rd_addr), .mem_rd_data_i(mem_rdat)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with requests present: no writes, read enables follow video only
      reset_ni = 1'b0; host_sel = 1'b1; host_wr = 1'b0; host_addr = 16'h8000; host_data = 16'h0000;
      wm_sel = 2'b01; wm_addr = {16'hC002, 16'h8001}; wm_data = {16'h2222, 16'h1111};
      xreg_rdat = 16'h7777; vid_sel = 3'b100; vid_addr = {16'h0333, 16'h0222, 16'h0111};
      mem_rdat = {16'h3333, 16'h2222, 16'hBEEF};
      @(negedge clk);
      chk("rst_host_ack", 48'(host_ack), 48'd0);
      chk("rst_wm_ack", 48'(wm_ack), 48'd0);
      chk("rst_host_data", 48'(host_rdat), 48'd0);
      chk("rst_wr_en", 48'(mem_wr_en), 48'd0);
      chk("rst_xreg_wr", 48'(xreg_wr), 48'd0);
      chk("rst_rd_en", 48'(mem_rd_en), 48'b100);
      nxt(); host_sel = 1'b0; vid_sel = 3'b000; wm_sel = 2'b00;
      @(negedge clk);

      // both masters held: round robin alternates, fixed priority starves master 1
      nxt(); reset_ni = 1'b1; wm_sel = 2'b11;
      @(negedge clk);
      chk("c1_wr_en", 48'(mem_wr_en), 48'b001);
      chk("c1_wr_addr", 48'(mem_wr_addr), 48'h8001);
      chk("c1_wr_data", 48'(mem_wr_data), 48'h1111);
      chk("c1_ack", 48'(wm_ack), 48'd0);
      nxt(); @(negedge clk);
      chk("c2_ack", 48'(wm_ack), 48'b01);
      chk("c2_wr_en", 48'(mem_wr_en), 48'b100);
      chk("c2_wr_data", 48'(mem_wr_data), 48'h2222);
      chk("fp_c2_ack", 48'(fp_wm_ack), 48'b01);
      chk("fp_c2_wr_en", 48'(fp_mem_wr_en), 48'b000);
      nxt(); @(negedge clk);
      chk("c3_ack", 48'(wm_ack), 48'b10);
      chk("c3_wr_en", 48'(mem_wr_en), 48'b001);
      chk("fp_c3_ack", 48'(fp_wm_ack), 48'b00);
      chk("fp_c3_wr_en", 48'(fp_mem_wr_en), 48'b001);
      nxt(); @(negedge clk);
      chk("c4_ack", 48'(wm_ack), 48'b01);
      chk("c4_wr_en", 48'(mem_wr_en), 48'b100);
      chk("fp_c4_ack", 48'(fp_wm_ack), 48'b01);
      nxt(); wm_sel = 2'b00;
      @(negedge clk);
      chk("c5_ack", 48'(wm_ack), 48'b10);
      chk("c5_wr_en", 48'(mem_wr_en), 48'b000);
      chk("fp_c5_ack", 48'(fp_wm_ack), 48'b00);

      // host write starved by master 0, forced through on its 4th pending cycle
      nxt(); wm_sel = 2'b01; host_sel = 1'b1; host_wr = 1'b1; host_addr = 16'hA010; host_data = 16'h1234;
      @(negedge clk);
      chk("d1_wr_en", 48'(mem_wr_en), 48'b001);
      nxt(); @(negedge clk);
      chk("d2_wr_en", 48'(mem_wr_en), 48'b000);
      chk("d2_wm_ack", 48'(wm_ack), 48'b01);
      nxt(); @(negedge clk);
      chk("d3_wr_en", 48'(mem_wr_en), 48'b001);
      chk("d3_host_ack", 48'(host_ack), 48'd0);
      nxt(); @(negedge clk);
      chk("d4_wr_en", 48'(mem_wr_en), 48'b010);
      chk("d4_wr_addr", 48'(mem_wr_addr), 48'hA010);
      chk("d4_wr_data", 48'(mem_wr_data), 48'h1234);
      chk("d4_host_ack", 48'(host_ack), 48'd0);
      nxt(); @(negedge clk);
      chk("d5_host_ack", 48'(host_ack), 48'd1);
      chk("d5_wr_en", 48'(mem_wr_en), 48'b001);
      nxt(); host_sel = 1'b0; host_wr = 1'b0; wm_sel = 2'b00;
      @(negedge clk);
      chk("d6_host_ack", 48'(host_ack), 48'd0);

      // host color read waits for video, then returns and holds the data
      nxt(); host_sel = 1'b1; host_addr = 16'h8005; vid_sel = 3'b001;
      @(negedge clk);
      chk("e1_rd_en", 48'(mem_rd_en), 48'b001);
      chk("e1_rd_addr", mem_rd_addr, {16'h8005, 16'h8005, 16'h0111});
      nxt(); nxt(); @(negedge clk);
      chk("e3_host_ack", 48'(host_ack), 48'd0);
      nxt(); vid_sel = 3'b000;
      @(negedge clk);
      chk("e4_rd_en", 48'(mem_rd_en), 48'b001);
      chk("e4_rd_addr", mem_rd_addr, {16'h8005, 16'h8005, 16'h8005});
      chk("e4_host_ack", 48'(host_ack), 48'd0);
      nxt(); @(negedge clk);
      chk("e5_host_ack", 48'(host_ack), 48'd1);
      chk("e5_host_data", 48'(host_rdat), 48'hBEEF);
      nxt(); host_sel = 1'b0; mem_rdat = '0;
      @(negedge clk);
      chk("e6_host_ack", 48'(host_ack), 48'd0);
      chk("e6_host_data", 48'(host_rdat), 48'hBEEF);

      // unmapped read and write: acked, zero data, no enables
      nxt(); host_sel = 1'b1; host_addr = 16'hE000; mem_rdat = {16'h3333, 16'h2222, 16'hBEEF};
      @(negedge clk);
      chk("f1_rd_en", 48'(mem_rd_en), 48'b000);
      chk("f1_wr_en", 48'(mem_wr_en), 48'b000);
      nxt(); @(negedge clk);
      chk("f2_host_ack", 48'(host_ack), 48'd1);
      chk("f2_host_data", 48'(host_rdat), 48'h0000);
      nxt(); host_sel = 1'b0;
      @(negedge clk);
      chk("f3_host_data", 48'(host_rdat), 48'h0000);
      nxt(); host_sel = 1'b1; host_wr = 1'b1; host_data = 16'h5555;
      @(negedge clk);
      chk("g1_wr_en", 48'(mem_wr_en), 48'b000);
      chk("g1_xreg_wr", 48'(xreg_wr), 48'd0);
      nxt(); @(negedge clk);
      chk("g2_host_ack", 48'(host_ack), 48'd1);
      nxt(); host_sel = 1'b0; host_wr = 1'b0;
      @(negedge clk);

      // register write blocks a register read for one cycle
      nxt(); wm_sel = 2'b01; wm_addr = {16'hC002, 16'h0010}; wm_data = {16'h2222, 16'hAAAA};
      host_sel = 1'b1; host_addr = 16'h0020;
      @(negedge clk);
      chk("h1_xreg_wr", 48'(xreg_wr), 48'd1);
      chk("h1_xreg_addr", 48'(xreg_addr), 48'h0010);
      chk("h1_xreg_data", 48'(xreg_wdat), 48'hAAAA);
      nxt(); wm_sel = 2'b00;
      @(negedge clk);
      chk("h2_xreg_wr", 48'(xreg_wr), 48'd0);
      chk("h2_xreg_addr", 48'(xreg_addr), 48'h0020);
      chk("h2_wm_ack", 48'(wm_ack), 48'b01);
      chk("h2_host_ack", 48'(host_ack), 48'd0);
      nxt(); host_sel = 1'b0;
      @(negedge clk);
      chk("h3_host_ack", 48'(host_ack), 48'd1);
      chk("h3_host_data", 48'(host_rdat), 48'h7777);

      // reset lands on master 1's turn: no ack, restart from master 0
      nxt(); wm_sel = 2'b11; wm_addr = {16'hC002, 16'h8001}; reset_ni = 1'b0;
      @(negedge clk);
      chk("j1_wr_en", 48'(mem_wr_en), 48'b000);
      nxt(); reset_ni = 1'b1;
      @(negedge clk);
      chk("j2_ack", 48'(wm_ack), 48'b00);
      chk("j2_wr_en", 48'(mem_wr_en), 48'b001);
      nxt(); @(negedge clk);
      chk("j3_ack", 48'(wm_ack), 48'b01);
      chk("j3_wr_en", 48'(mem_wr_en), 48'b100);
      nxt(); wm_sel = 2'b00;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
